req_dispatcher: RTL and testbench

REQ_DISPATCHER -- requirements
Module: req_dispatcher

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/req_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_req_dispatcher.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the request dispatcher: opcodes, unit IDs,
// fixed key width code and FSM state encoding.
package ctrl_pkg;

    typedef enum logic [1:0] {
        CPU_AES_ENC = 2'd0,
        CPU_AES_DEC = 2'd1,
        CPU_SHA     = 2'd2,
        CPU_RSVD    = 2'd3
    } cpu_op_e;

    typedef enum logic [1:0] {
        OP_RD      = 2'd0,
        OP_WR      = 2'd1,
        OP_RUN     = 2'd2,
        OP_RUN_INV = 2'd3
    } int_op_e;

    localparam int unsigned UNIT_MEM  = 0;
    localparam int unsigned UNIT_AES  = 1;
    localparam int unsigned UNIT_SHA  = 2;
    localparam int unsigned UNIT_CTRL = 3;

    localparam logic [3:0] KEY_W_ENC = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_TEXT = 3'd2,
        ST_EXEC = 3'd3,
        ST_WAIT = 3'd4,
        ST_WB   = 3'd5
    } state_e;

    // SHA requests go to the SHA engine, everything else to AES.
    function automatic int unsigned engine_of(input logic [1:0] op);
        return (op == CPU_SHA) ? UNIT_SHA : UNIT_AES;
    endfunction

endpackage

// File: rtl/req_dispatcher.sv
// Turns one CPU crypto request into the internal sequence key load, text load,
// execute, wait for engine, write back; outputs are registered from next state.
module req_dispatcher
    import ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned CPU_W_ENC_W = 3,
    parameter int unsigned INT_W_ENC_W = 4,
    parameter int unsigned OPCODE_W    = 2,
    parameter int unsigned SRC_ID_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      cpu_text_addr,
    input  logic [CPU_W_ENC_W-1:0] cpu_text_width,
    input  logic [ADDR_W-1:0]      cpu_key_addr,
    input  logic [OPCODE_W-1:0]    cpu_opcode,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    output logic [ADDR_W-1:0]      int_addr,
    output logic [INT_W_ENC_W-1:0] int_width,
    output logic [SRC_ID_W-1:0]    int_dest,
    output logic [SRC_ID_W-1:0]    int_source_id,
    output logic [OPCODE_W-1:0]    int_opcode,
    output logic                   int_valid,
    input  logic                   int_ready,
    input  logic                   eng_done,
    output logic                   done,
    output logic                   err
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0]      text_addr_q, key_addr_q;
    logic [CPU_W_ENC_W-1:0] text_width_q;
    logic [OPCODE_W-1:0]    opcode_q;

    logic [ADDR_W-1:0]      eff_text_addr, eff_key_addr;
    logic [CPU_W_ENC_W-1:0] eff_text_width;
    logic [OPCODE_W-1:0]    eff_opcode;
    logic [SRC_ID_W-1:0]    eng_id;

    logic                   accept, hs;
    logic                   valid_d, done_d, err_d;
    logic [ADDR_W-1:0]      addr_d;
    logic [INT_W_ENC_W-1:0] width_d;
    logic [SRC_ID_W-1:0]    dest_d, src_d;
    logic [OPCODE_W-1:0]    op_d;

    assign accept = cpu_valid && cpu_ready;
    assign hs     = int_valid && int_ready;

    // Next state plus the issue that state will present; on accept the
    // incoming CPU fields are used because the latches are not loaded yet.
    always_comb begin
        state_d        = state_q;
        valid_d        = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;
        addr_d         = '0;
        width_d        = '0;
        dest_d         = '0;
        src_d          = '0;
        op_d           = '0;
        eff_text_addr  = text_addr_q;
        eff_key_addr   = key_addr_q;
        eff_text_width = text_width_q;
        eff_opcode     = opcode_q;
        if (accept) begin
            eff_text_addr  = cpu_text_addr;
            eff_key_addr   = cpu_key_addr;
            eff_text_width = cpu_text_width;
            eff_opcode     = cpu_opcode;
        end
        eng_id = SRC_ID_W'(engine_of(2'(eff_opcode)));

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (eff_opcode == OPCODE_W'(CPU_RSVD)) begin
                        err_d = 1'b1;
                    end else if (eff_opcode == OPCODE_W'(CPU_SHA)) begin
                        state_d = ST_TEXT;
                    end else begin
                        state_d = ST_KEY;
                    end
                end
            end
            ST_KEY:  if (hs) state_d = ST_TEXT;
            ST_TEXT: if (hs) state_d = ST_EXEC;
            ST_EXEC: if (hs) state_d = ST_WAIT;
            ST_WAIT: if (eng_done) state_d = ST_WB;
            ST_WB: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_KEY: begin
                valid_d = 1'b1;
                addr_d  = eff_key_addr;
                width_d = INT_W_ENC_W'(KEY_W_ENC);
                op_d    = OPCODE_W'(OP_RD);
                src_d   = SRC_ID_W'(UNIT_MEM);
                dest_d  = eng_id;
            end
            ST_TEXT: begin
                valid_d = 1'b1;
                addr_d  = eff_text_addr;
                width_d = INT_W_ENC_W'(eff_text_width);
                op_d    = OPCODE_W'(OP_RD);
                src_d   = SRC_ID_W'(UNIT_MEM);
                dest_d  = eng_id;
            end
            ST_EXEC: begin
                valid_d = 1'b1;
                op_d    = (eff_opcode == OPCODE_W'(CPU_AES_DEC)) ? OPCODE_W'(OP_RUN_INV)
                                                                 : OPCODE_W'(OP_RUN);
                src_d   = SRC_ID_W'(UNIT_CTRL);
                dest_d  = eng_id;
            end
            ST_WB: begin
                valid_d = 1'b1;
                addr_d  = eff_text_addr;
                width_d = INT_W_ENC_W'(eff_text_width);
                op_d    = OPCODE_W'(OP_WR);
                src_d   = eng_id;
                dest_d  = SRC_ID_W'(UNIT_MEM);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cpu_ready     <= 1'b1;
            int_valid     <= 1'b0;
            int_addr      <= '0;
            int_width     <= '0;
            int_dest      <= '0;
            int_source_id <= '0;
            int_opcode    <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            text_addr_q   <= '0;
            key_addr_q    <= '0;
            text_width_q  <= '0;
            opcode_q      <= '0;
        end else begin
            state_q       <= state_d;
            cpu_ready     <= (state_d == ST_IDLE);
            int_valid     <= valid_d;
            int_addr      <= addr_d;
            int_width     <= width_d;
            int_dest      <= dest_d;
            int_source_id <= src_d;
            int_opcode    <= op_d;
            done          <= done_d;
            err           <= err_d;
            if (accept) begin
                text_addr_q  <= cpu_text_addr;
                key_addr_q   <= cpu_key_addr;
                text_width_q <= cpu_text_width;
                opcode_q     <= cpu_opcode;
            end
        end
    end

endmodule

// File: tb/tb_req_dispatcher.sv
// Scoreboard bench for req_dispatcher: expected issues are queued when a
// request is driven and compared on every valid cycle of the internal port.
module tb_req_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] cpu_text_addr, cpu_key_addr;
    logic [2:0] cpu_text_width;
    logic [1:0] cpu_opcode;
    logic       cpu_valid, cpu_ready;
    logic [9:0] int_addr;
    logic [3:0] int_width;
    logic [2:0] int_dest, int_source_id;
    logic [1:0] int_opcode;
    logic       int_valid, int_ready, eng_done, done, err;

    typedef struct packed {
        logic [9:0] addr;
        logic [3:0] width;
        logic [2:0] dest;
        logic [2:0] src;
        logic [1:0] op;
    } issue_t;

    issue_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    req_dispatcher dut (
        .clk(clk), .rst(rst),
        .cpu_text_addr(cpu_text_addr), .cpu_text_width(cpu_text_width),
        .cpu_key_addr(cpu_key_addr), .cpu_opcode(cpu_opcode),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .int_addr(int_addr), .int_width(int_width), .int_dest(int_dest),
        .int_source_id(int_source_id), .int_opcode(int_opcode),
        .int_valid(int_valid), .int_ready(int_ready),
        .eng_done(eng_done), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic issue_t mk(input logic [9:0] a, input logic [3:0] w,
                                  input logic [2:0] d, input logic [2:0] s, input logic [1:0] o);
        issue_t it;
        it.addr = a; it.width = w; it.dest = d; it.src = s; it.op = o;
        return it;
    endfunction

    task automatic push_expected(input logic [1:0] op, input logic [9:0] key,
                                 input logic [9:0] text, input logic [2:0] w);
        logic [2:0] eng;
        eng = (op == 2'd2) ? 3'd2 : 3'd1;
        if (op != 2'd2) sb_q.push_back(mk(key, 4'd5, eng, 3'd0, 2'd0));
        sb_q.push_back(mk(text, {1'b0, w}, eng, 3'd0, 2'd0));
        sb_q.push_back(mk(10'd0, 4'd0, eng, 3'd3, (op == 2'd1) ? 2'd3 : 2'd2));
        sb_q.push_back(mk(text, {1'b0, w}, 3'd0, eng, 2'd1));
    endtask

    // Drive one request and service the internal port until done (or abort in WAIT).
    task automatic run_req(input logic [1:0] op, input logic [9:0] key, input logic [9:0] text,
                           input logic [2:0] w, input int stall, input bit spurious,
                           input bit abort, input int exp_lat);
        bit pend = 0, got = 0, abort_now = 0;
        int stall_left = stall;
        int exec_cycles = 0;
        issue_t exp_it;
        @(negedge clk);
        check("accept_ready", cpu_ready, 1);
        cpu_valid = 1; cpu_opcode = op; cpu_key_addr = key;
        cpu_text_addr = text; cpu_text_width = w;
        push_expected(op, key, text, w);
        @(posedge clk);
        #1 cpu_valid = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (abort_now) begin
                rst = 1;
                #1;
                check("rst_int_valid", int_valid, 0);
                check("rst_cpu_ready", cpu_ready, 1);
                check("rst_fields", {int_addr, int_width, int_dest, int_source_id, int_opcode}, 0);
                @(negedge clk);
                rst = 0;
                sb_q.delete();
                repeat (3) begin
                    @(negedge clk);
                    check("no_done_after_rst", done, 0);
                end
                return;
            end
            eng_done = pend | (spurious && cyc == 1);
            pend = 0;
            if (cyc == 1) check("busy_ready", cpu_ready, 0);
            check("no_err", err, 0);
            if (done) begin
                check("done_lat", cyc, exp_lat);
                check("ready_at_done", cpu_ready, 1);
                got = 1;
                break;
            end
            if (int_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_issue", int_valid, 0);
                end else begin
                    exp_it = sb_q[0];
                    check("issue", {int_addr, int_width, int_dest, int_source_id, int_opcode}, exp_it);
                    if (exp_it.src == 3'd3) exec_cycles++;
                    if (exp_it.src == 3'd3 && stall_left > 0) begin
                        int_ready = 0;
                        stall_left--;
                    end else begin
                        int_ready = 1;
                        void'(sb_q.pop_front());
                        if (exp_it.src == 3'd3) begin
                            if (abort) abort_now = 1;
                            else pend = 1;
                        end
                    end
                end
            end else begin
                int_ready = 1;
            end
        end
        eng_done = 0;
        if (!got) check("timeout", 0, 1);
        if (stall > 0) check("exec_valid_cycles", exec_cycles, stall + 1);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        rst = 1; cpu_valid = 0; cpu_opcode = 0; cpu_key_addr = 0;
        cpu_text_addr = 0; cpu_text_width = 0; int_ready = 0; eng_done = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("reset_cpu_ready", cpu_ready, 1);
        check("reset_int_valid", int_valid, 0);
        check("reset_done_err", {done, err}, 0);
        check("reset_fields", {int_addr, int_width, int_dest, int_source_id, int_opcode}, 0);

        run_req(2'd0, 10'h040, 10'h100, 3'd3, 0, 0, 0, 6);
        run_req(2'd2, 10'h000, 10'h200, 3'd5, 0, 1, 0, 5);
        run_req(2'd1, 10'h3ff, 10'h155, 3'd7, 3, 0, 0, 9);

        // Reserved opcode: single err pulse, nothing issued, still ready.
        @(negedge clk);
        cpu_valid = 1; cpu_opcode = 2'd3; cpu_key_addr = 10'h011; cpu_text_addr = 10'h022;
        @(posedge clk);
        #1 cpu_valid = 0;
        @(negedge clk);
        check("rsvd_err", err, 1);
        check("rsvd_ready", cpu_ready, 1);
        check("rsvd_no_valid", int_valid, 0);
        @(negedge clk);
        check("rsvd_err_once", err, 0);
        check("rsvd_no_valid2", int_valid, 0);

        run_req(2'd0, 10'h0aa, 10'h0bb, 3'd2, 0, 0, 1, 0);
        run_req(2'd2, 10'h000, 10'h2c4, 3'd1, 0, 0, 0, 5);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
